// File: rtl/mesi_isc_cpu_agent_if.sv
// Signal bundle for the MESI ISC CPU agent: CPU request port, main bus and coherence bus.
// The master modport is the agent's view; slave is the view of the CPU/controller side.
interface mesi_isc_cpu_agent_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic                  cpu_ready_o;
    logic                  cpu_done_o;
    logic [2:0]            mbus_cmd_o;
    logic [ADDR_WIDTH-1:0] mbus_addr_o;
    logic                  mbus_ack_i;
    logic [2:0]            cbus_cmd_i;
    logic [ADDR_WIDTH-1:0] cbus_addr_i;
    logic                  cbus_ack_o;

    modport master (
        input  cpu_req_i,
        input  cpu_we_i,
        input  cpu_addr_i,
        output cpu_ready_o,
        output cpu_done_o,
        output mbus_cmd_o,
        output mbus_addr_o,
        input  mbus_ack_i,
        input  cbus_cmd_i,
        input  cbus_addr_i,
        output cbus_ack_o
    );

    modport slave (
        output cpu_req_i,
        output cpu_we_i,
        output cpu_addr_i,
        input  cpu_ready_o,
        input  cpu_done_o,
        input  mbus_cmd_o,
        input  mbus_addr_o,
        output mbus_ack_i,
        output cbus_cmd_i,
        output cbus_addr_i,
        input  cbus_ack_o
    );
endinterface

// File: rtl/mesi_isc_cpu_agent.sv
// MESI ISC CPU agent: broadcast/enable/access request sequencer plus an independent snoop responder.
// Optional MESI_ISC_CPU_AGENT_STATS_EN adds snoop_cnt_o, a saturating count of snoop acknowledges.
//
// state   | meaning
// IDLE    | ready for a CPU request
// BROAD   | WR_BROAD/RD_BROAD on main bus until acked
// WAIT_EN | waiting for matching EN_WR/EN_RD on coherence bus
// ACCESS  | WR/RD on main bus until acked, then done pulse
module mesi_isc_cpu_agent #(
    parameter int ADDR_WIDTH = 32,
    parameter int SNOOP_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mesi_isc_cpu_agent_if.master  bus
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
    ,
    output logic [15:0]           snoop_cnt_o
`endif
);

    localparam logic [2:0] MBUS_NOP      = 3'd0;
    localparam logic [2:0] MBUS_WR       = 3'd1;
    localparam logic [2:0] MBUS_RD       = 3'd2;
    localparam logic [2:0] MBUS_WR_BROAD = 3'd3;
    localparam logic [2:0] MBUS_RD_BROAD = 3'd4;

    localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
    localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
    localparam logic [2:0] CBUS_EN_WR    = 3'd3;
    localparam logic [2:0] CBUS_EN_RD    = 3'd4;

    localparam logic [3:0] SNOOP_LOAD = 4'(SNOOP_LAT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BROAD   = 2'd1,
        WAIT_EN = 2'd2,
        ACCESS  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  en_ack_q, en_ack_d;
    logic [3:0]            snp_cnt_q, snp_cnt_d;
    logic                  cool_q, cool_d;

    logic                  en_hit;
    logic                  snoop_cmd;
    logic                  snoop_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            en_ack_q  <= 1'b0;
            snp_cnt_q <= 4'd0;
            cool_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            done_q    <= done_d;
            en_ack_q  <= en_ack_d;
            snp_cnt_q <= snp_cnt_d;
            cool_q    <= cool_d;
        end
    end

    assign en_hit = (bus.cbus_cmd_i == (we_q ? CBUS_EN_WR : CBUS_EN_RD)) &&
                    (bus.cbus_addr_i == addr_q);

    // done_q holds off acceptance so the completion cycle never overlaps a new request
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        we_d             = we_q;
        done_d           = 1'b0;
        en_ack_d         = 1'b0;
        bus.cpu_ready_o  = 1'b0;
        bus.mbus_cmd_o   = MBUS_NOP;
        bus.mbus_addr_o  = '0;
        case (state_q)
            IDLE: begin
                bus.cpu_ready_o = !done_q;
                if (bus.cpu_req_i && !done_q) begin
                    addr_d  = bus.cpu_addr_i;
                    we_d    = bus.cpu_we_i;
                    state_d = BROAD;
                end
            end
            BROAD: begin
                bus.mbus_cmd_o  = we_q ? MBUS_WR_BROAD : MBUS_RD_BROAD;
                bus.mbus_addr_o = addr_q;
                if (bus.mbus_ack_i) begin
                    state_d = WAIT_EN;
                end
            end
            WAIT_EN: begin
                if (en_hit) begin
                    en_ack_d = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                bus.mbus_cmd_o  = we_q ? MBUS_WR : MBUS_RD;
                bus.mbus_addr_o = addr_q;
                if (bus.mbus_ack_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign snoop_cmd = (bus.cbus_cmd_i == CBUS_WR_SNOOP) || (bus.cbus_cmd_i == CBUS_RD_SNOOP);

    // Ack fires on the last count; the following cycle is a cooldown that swallows a held command
    assign snoop_ack = (snp_cnt_q == 4'd1);

    always_comb begin
        snp_cnt_d = snp_cnt_q;
        cool_d    = snoop_ack;
        if (snp_cnt_q != 4'd0) begin
            snp_cnt_d = snp_cnt_q - 4'd1;
        end else if (snoop_cmd && !cool_q) begin
            snp_cnt_d = SNOOP_LOAD;
        end
    end

    assign bus.cbus_ack_o = en_ack_q || snoop_ack;
    assign bus.cpu_done_o = done_q;

`ifdef MESI_ISC_CPU_AGENT_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (snoop_ack && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= 16'd0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign snoop_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// Scoreboard bench for mesi_isc_cpu_agent: a transaction-level model schedules expected bus
// activity by cycle number, and a negedge monitor compares every cycle against it.
`timescale 1ns/1ps
module tb_mesi_isc_cpu_agent;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam int BIG = 32'h7fffffff;

    localparam logic [2:0] C_NOP      = 3'd0;
    localparam logic [2:0] C_WR_SNOOP = 3'd1;
    localparam logic [2:0] C_RD_SNOOP = 3'd2;
    localparam logic [2:0] C_EN_WR    = 3'd3;
    localparam logic [2:0] C_EN_RD    = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mesi_isc_cpu_agent_if #(.ADDR_WIDTH(AW)) bus ();
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
    logic [15:0] snoop_cnt;
`endif

    mesi_isc_cpu_agent #(.ADDR_WIDTH(AW), .SNOOP_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
        ,
        .snoop_cnt_o (snoop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [2:0]     cmd;
        logic [AW-1:0]  addr;
    } mbus_exp_t;

    mbus_exp_t     mq[$];
    int            aq[$];
    int            dq[$];
    int            busy_lo = -1;
    int            busy_hi = -1;
    int            last_done = -1;
    int            snp_free = 0;
    int            exp_snoops = 0;
    int            n_vec = 0;
    int            n_fail = 0;
    logic [AW-1:0] cur_addr = '0;
    bit            rnd_snoop = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // acks landing in the same cycle merge into one pulse
    task automatic push_ack(input int c);
        int i;
        i = 0;
        while (i < aq.size() && aq[i] < c) i++;
        if (i < aq.size() && aq[i] == c) return;
        aq.insert(i, c);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0]    ecmd;
        logic [AW-1:0] eaddr;
        logic          eack, edone, erdy;
        if (cyc >= 1) begin
            ecmd  = C_NOP;
            eaddr = '0;
            if (mq.size() > 0 && mq[0].cyc == cyc) begin
                ecmd  = mq[0].cmd;
                eaddr = mq[0].addr;
                void'(mq.pop_front());
            end
            chk("mbus_cmd", 64'(bus.mbus_cmd_o), 64'(ecmd));
            chk("mbus_addr", 64'(bus.mbus_addr_o), 64'(eaddr));
            eack = (aq.size() > 0 && aq[0] == cyc);
            if (eack) void'(aq.pop_front());
            chk("cbus_ack", 64'(bus.cbus_ack_o), 64'(eack));
            edone = (dq.size() > 0 && dq[0] == cyc);
            if (edone) void'(dq.pop_front());
            chk("cpu_done", 64'(bus.cpu_done_o), 64'(edone));
            erdy = !(cyc > busy_lo && cyc <= busy_hi);
            chk("cpu_ready", 64'(bus.cpu_ready_o), 64'(erdy));
        end
    end

    task automatic step(input logic [2:0] cc, input logic [AW-1:0] ca, input logic ma);
        bus.cbus_cmd_i  = cc;
        bus.cbus_addr_i = ca;
        bus.mbus_ack_i  = ma;
        if (!rst && (cc == C_WR_SNOOP || cc == C_RD_SNOOP) && cyc >= snp_free) begin
            push_ack(cyc + LAT);
            snp_free = cyc + LAT + 2;
            if (exp_snoops < 65535) exp_snoops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic ma);
        logic [2:0]    cc;
        logic [AW-1:0] ca;
        cc = C_NOP;
        ca = $urandom;
        if (rnd_snoop && $urandom_range(0, 3) == 0) begin
            cc = ($urandom_range(0, 1) == 1) ? C_WR_SNOOP : C_RD_SNOOP;
            if ($urandom_range(0, 1) == 1) ca = cur_addr;
        end
        step(cc, ca, ma);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        while (aq.size() > 0 && aq[$] > cyc) void'(aq.pop_back());
        while (mq.size() > 0 && mq[$].cyc > cyc) void'(mq.pop_back());
        while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
        snp_free   = cyc + 1;
        exp_snoops = 0;
        if (busy_hi > cyc) busy_hi = cyc;
        last_done  = -1;
        step(C_NOP, '0, 1'b0);
        rst = 1'b0;
    endtask

    // decoy: 0 none, 1 addr^1, 2 wrong EN type, 3 random flipped address bit
    task automatic do_txn(input logic we, input logic [AW-1:0] a, input int bw, input int ew,
                          input int aw, input int decoy, input bit coll, input bit abort);
        logic [2:0] en;
        logic [2:0] bcmd, acmd;
        int         ke;
        en       = we ? C_EN_WR : C_EN_RD;
        bcmd     = we ? 3'd3 : 3'd4;
        acmd     = we ? 3'd1 : 3'd2;
        cur_addr = a;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = a;
        if (cyc == last_done) idle_step($urandom_range(0, 1) == 1);
        busy_lo = cyc;
        busy_hi = BIG;
        for (int i = 1; i <= bw + 1; i++) mq.push_back(mbus_exp_t'{cyc + i, bcmd, a});
        idle_step(1'b0);
        bus.cpu_req_i  = 1'b0;
        bus.cpu_we_i   = 1'($urandom);
        bus.cpu_addr_i = $urandom;
        for (int i = 0; i < bw; i++) idle_step(1'b0);
        idle_step(1'b1);
        for (int i = 0; i < ew; i++) begin
            if (i == ew - 1 && coll)            step(C_RD_SNOOP, a, 1'($urandom));
            else if (i == ew - 1 && decoy == 1) step(en, a ^ 32'h1, 1'($urandom));
            else if (i == ew - 1 && decoy == 2) step(we ? C_EN_RD : C_EN_WR, a, 1'($urandom));
            else if (i == ew - 1 && decoy == 3) step(en, a ^ (AW'(1) << $urandom_range(0, AW - 1)), 1'($urandom));
            else                                idle_step(1'($urandom));
        end
        ke = cyc;
        push_ack(ke + 1);
        for (int i = 1; i <= aw + 1; i++) mq.push_back(mbus_exp_t'{ke + i, acmd, a});
        step(en, a, 1'($urandom));
        for (int i = 0; i < aw; i++) begin
            if (abort && i == 0) step(C_WR_SNOOP, a ^ 32'h4, 1'b0);
            else                 idle_step(1'b0);
        end
        if (abort) begin
            do_reset();
        end else begin
            dq.push_back(cyc + 1);
            busy_hi = cyc + 1;
            idle_step(1'b1);
            last_done = cyc;
        end
    endtask

    initial begin
        int gap;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.mbus_ack_i  = 1'b0;
        bus.cbus_cmd_i  = C_NOP;
        bus.cbus_addr_i = '0;
        repeat (3) step(C_NOP, '0, 1'b0);
        rst = 1'b0;
        step(C_NOP, '0, 1'b1);

        // write at 0x1, straightforward handshake
        do_txn(1'b1, 32'h1, 2, 1, 1, 0, 1'b0, 1'b0);
        repeat (2) idle_step(1'b1);

        // read at 0x8 with EN_RD@0x9 first
        do_txn(1'b0, 32'h8, 1, 2, 2, 1, 1'b0, 1'b0);

        // held WR_SNOOP for four cycles
        repeat (LAT + 2) step(C_NOP, '0, 1'b0);
        repeat (4) step(C_WR_SNOOP, 32'h40, 1'b0);
        repeat (LAT + 3) step(C_NOP, '0, 1'b0);

        // snoop at latched address colliding with the EN acknowledge
        do_reset();
        do_txn(1'b0, 32'h100, 1, 2, 0, 0, 1'b1, 1'b0);
        repeat (LAT + 2) step(C_NOP, '0, 1'b0);
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
        chk("snoop_cnt_collision", 64'(snoop_cnt), 64'(exp_snoops));
`endif

        // reset in ACCESS with a snoop still in flight
        do_txn(1'b1, 32'hA0, 0, 0, 1, 0, 1'b0, 1'b1);
        repeat (3) idle_step(1'b0);

        rnd_snoop = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int ew;
            ew = $urandom_range(0, 3);
            do_txn(1'($urandom), $urandom, $urandom_range(0, 3), ew, $urandom_range(0, 3),
                   $urandom_range(0, 3), (ew > 0) && ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 9) == 0);
            gap = $urandom_range(0, 3);
            repeat (gap) idle_step(1'($urandom));
        end

        rnd_snoop = 1'b0;
        repeat (LAT + 3) step(C_NOP, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("pending_acks", 64'(aq.size()), 64'd0);
        chk("pending_mbus", 64'(mq.size()), 64'd0);
        chk("pending_done", 64'(dq.size()), 64'd0);
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
        chk("snoop_cnt_final", 64'(snoop_cnt), 64'(exp_snoops));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mesi_isc_cpu_agent.md
MESI_ISC_CPU_AGENT -- requirements
Module: mesi_isc_cpu_agent

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 32, address width.
- SNOOP_LAT, 2, cycles from snoop recognition to cbus_ack_o; legal range 1..15.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, system clock.
- rst, input, 1, active-high reset, synchronous to clk.
- cpu_req_i, input, 1, CPU miss/upgrade request valid.
- cpu_we_i, input, 1, 1 = write (WR_BROAD), 0 = read (RD_BROAD).
- cpu_addr_i, input, ADDR_WIDTH, request address.
- cpu_ready_o, output, 1, agent idle; a request is accepted when cpu_req_i && cpu_ready_o.
- cpu_done_o, output, 1, one-cycle pulse when the final RD/WR is acknowledged.
- mbus_cmd_o, output, 3, main bus command: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4.
- mbus_addr_o, output, ADDR_WIDTH, main bus address.
- mbus_ack_i, input, 1, main bus acknowledge from the coherence controller.
- cbus_cmd_i, input, 3, coherence command: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- cbus_addr_i, input, ADDR_WIDTH, coherence bus address.
- cbus_ack_o, output, 1, coherence bus acknowledge.

Function
REQ-003 Request FSM SHALL have exactly the states IDLE, BROAD, WAIT_EN, ACCESS.
REQ-004 IDLE SHALL behave as follows: cpu_ready_o=1, mbus_cmd_o=NOP; on acceptance, latch cpu_addr_i and cpu_we_i and move to BROAD.
REQ-005 BROAD SHALL drive mbus_cmd_o = WR_BROAD or RD_BROAD per latched type, with mbus_addr_o = latched address, until mbus_ack_i is sampled high; the next cycle SHALL be WAIT_EN with mbus_cmd_o=NOP.
REQ-006 WAIT_EN SHALL move to ACCESS on the cycle after cbus_cmd_i equals EN_WR (write) or EN_RD (read) and cbus_addr_i equals the latched address. A mismatched EN type or address SHALL be ignored.
REQ-007 The EN command SHALL be acknowledged by a one-cycle cbus_ack_o pulse in the cycle after recognition, with no SNOOP_LAT delay.
REQ-008 ACCESS SHALL drive mbus_cmd_o = WR or RD and mbus_addr_o = latched address until mbus_ack_i is sampled high. The next cycle SHALL assert cpu_done_o for one cycle and return to IDLE.
REQ-009 mbus_ack_i SHALL be ignored in IDLE and WAIT_EN.
REQ-010 mbus_cmd_o SHALL never take values 5..7, and mbus_addr_o SHALL be stable while mbus_cmd_o != NOP.
REQ-011 The snoop responder SHALL run independently of the request FSM: on cbus_cmd_i = WR_SNOOP or RD_SNOOP it loads a 4-bit counter with SNOOP_LAT and decrements each cycle. cbus_ack_o SHALL pulse for one cycle when the counter reaches 0, so the ack comes exactly SNOOP_LAT cycles after the snoop cycle.
REQ-012 While the counter is running, and for one cooldown cycle after the ack, further snoop commands SHALL be ignored, so a held command is not double-acknowledged.
REQ-013 If an EN acknowledge and a snoop acknowledge fall in the same cycle, a single cbus_ack_o pulse SHALL be driven and the snoop ack SHALL be considered delivered.
REQ-014 A snoop matching the latched address during WAIT_EN SHALL be acknowledged normally and SHALL NOT abort the request.
REQ-015 A new request SHALL NOT be accepted in the cycle cpu_done_o is high; cpu_ready_o=0 in that cycle.

Reset
REQ-016 When rst is sampled high, the block SHALL enter IDLE and clear the snoop counter and cooldown, with cpu_ready_o=1, cpu_done_o=0, mbus_cmd_o=NOP, mbus_addr_o=0, cbus_ack_o=0.
REQ-017 Reset mid-operation SHALL abandon the in-flight request without a cpu_done_o pulse and drop any pending snoop ack.

Configuration
REQ-018 With macro MESI_ISC_CPU_AGENT_STATS_EN defined, the block SHALL add output snoop_cnt_o[15:0], which increments on each snoop acknowledge, saturates at 16'hFFFF, and is cleared by rst. Without the macro, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 Write at addr 0x1: cpu_req_i=1, cpu_we_i=1 -> mbus_cmd_o=3 until ack; then EN_WR@0x1 -> cbus_ack_o one cycle later; then mbus_cmd_o=1 until ack; cpu_done_o pulses once.
REQ-020 Read at 0x8 with EN_RD@0x9 first, then EN_RD@0x8 -> the first is ignored; ACCESS is entered only after 0x8, driving mbus_cmd_o=2.
REQ-021 SNOOP_LAT=2, WR_SNOOP held 4 cycles -> exactly one cbus_ack_o, 2 cycles after the first snoop cycle.
REQ-022 Snoop arriving during WAIT_EN with an EN in the same window -> acks not lost; the request completes; snoop_cnt_o=1 when MESI_ISC_CPU_AGENT_STATS_EN is defined.
REQ-023 rst asserted during ACCESS -> next cycle mbus_cmd_o=0, cpu_ready_o=1, no cpu_done_o, cbus_ack_o=0.
